// File: rtl/codec_i2c_init_seq_pkg.sv
// Shared types and helpers for the codec power-up sequencer and its I2C byte writer.
package codec_i2c_init_seq_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_LOAD,
    ST_XFER,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } seq_state_e;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_START,
    PH_BITS,
    PH_STOP,
    PH_FREE
  } i2c_phase_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  function automatic int unsigned calc_qdiv(input int unsigned clk_hz, input int unsigned i2c_hz);
    return clk_hz / (4 * i2c_hz);
  endfunction

endpackage

// File: rtl/codec_i2c_init_seq_if.sv
// Control/status and register-table interface between the audio top and the sequencer.
interface codec_i2c_init_seq_if;
  logic        Reinit;
  logic [7:0]  Tbl_Idx;
  logic [15:0] Tbl_Data;
  logic        Init_Done;
  logic        Init_Err;
  logic        Busy;

  modport master (
    input  Reinit,
    input  Tbl_Data,
    output Tbl_Idx,
    output Init_Done,
    output Init_Err,
    output Busy
  );

  modport slave (
    output Reinit,
    output Tbl_Data,
    input  Tbl_Idx,
    input  Init_Done,
    input  Init_Err,
    input  Busy
  );
endinterface

// File: rtl/codec_i2c_init_seq_byte_writer.sv
// Single-master I2C writer: START, three bytes with ACK sampling, STOP, then one bus-free bit.
module codec_i2c_init_seq_byte_writer
  import codec_i2c_init_seq_pkg::*;
#(
  parameter int unsigned QDIV = 10
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_value,
  input  logic       sda_in,
  output logic       done,
  output logic       nack,
  output logic       scl,
  output logic       sda_oe
);

  localparam int QW = $clog2(QDIV);

  i2c_phase_e    ph, ph_n;
  logic [QW-1:0] qcnt;
  logic [1:0]    q, q_n;
  logic [1:0]    byte_idx, byte_n;
  logic [3:0]    bit_idx, bit_n;
  logic          scl_n, oe_n, nack_n, done_n;
  logic          tick;
  logic [23:0]   frame;

  // sda_oe=1 pulls SDA low; a '1' data bit is sent by releasing the line
  function automatic logic frame_bit(input logic [23:0] frm, input logic [1:0] b, input logic [2:0] i);
    logic [4:0] pos;
    pos = 5'd23 - {b, 3'b000} - {2'b00, i};
    return frm[pos];
  endfunction

  assign frame = {dev_addr, 1'b0, reg_addr, reg_value};
  assign tick  = (ph != PH_IDLE) && (qcnt == QW'(QDIV - 1));

  always_comb begin
    ph_n   = ph;
    q_n    = q;
    byte_n = byte_idx;
    bit_n  = bit_idx;
    scl_n  = scl;
    oe_n   = sda_oe;
    nack_n = nack;
    done_n = 1'b0;
    if (ph == PH_IDLE) begin
      scl_n = 1'b1;
      oe_n  = 1'b0;
      if (start) begin
        ph_n   = PH_START;
        q_n    = 2'd0;
        nack_n = 1'b0;
      end
    end else if (tick) begin
      // outputs below are the values for the quarter being entered (q+1)
      q_n = q + 2'd1;
      unique case (ph)
        PH_START: begin
          case (q)
            2'd0: oe_n = 1'b1;
            2'd2: scl_n = 1'b0;
            2'd3: begin
              ph_n   = PH_BITS;
              byte_n = 2'd0;
              bit_n  = 4'd0;
              oe_n   = ~frame_bit(frame, 2'd0, 3'd0);
            end
            default: ;
          endcase
        end
        PH_BITS: begin
          case (q)
            2'd1: scl_n = 1'b1;
            2'd2: if (bit_idx == 4'd8 && sda_in != I2C_ACK) nack_n = 1'b1;
            2'd3: begin
              scl_n = 1'b0;
              if (bit_idx == 4'd8) begin
                if (byte_idx == 2'd2) begin
                  ph_n = PH_STOP;
                  oe_n = 1'b1;
                end else begin
                  byte_n = byte_idx + 2'd1;
                  bit_n  = 4'd0;
                  oe_n   = ~frame_bit(frame, byte_idx + 2'd1, 3'd0);
                end
              end else if (bit_idx == 4'd7) begin
                bit_n = 4'd8;
                oe_n  = 1'b0;
              end else begin
                bit_n = bit_idx + 4'd1;
                oe_n  = ~frame_bit(frame, byte_idx, bit_idx[2:0] + 3'd1);
              end
            end
            default: ;
          endcase
        end
        PH_STOP: begin
          case (q)
            2'd1: scl_n = 1'b1;
            2'd2: oe_n = 1'b0;
            2'd3: ph_n = PH_FREE;
            default: ;
          endcase
        end
        PH_FREE: begin
          if (q == 2'd3) begin
            ph_n   = PH_IDLE;
            done_n = 1'b1;
          end
        end
        default: ph_n = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ph       <= PH_IDLE;
      qcnt     <= '0;
      q        <= 2'd0;
      byte_idx <= 2'd0;
      bit_idx  <= 4'd0;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
      nack     <= 1'b0;
      done     <= 1'b0;
    end else begin
      ph       <= ph_n;
      q        <= q_n;
      byte_idx <= byte_n;
      bit_idx  <= bit_n;
      scl      <= scl_n;
      sda_oe   <= oe_n;
      nack     <= nack_n;
      done     <= done_n;
      if (ph == PH_IDLE || tick) qcnt <= '0;
      else                       qcnt <= qcnt + QW'(1);
    end
  end

endmodule

// File: rtl/codec_i2c_init_seq.sv
// Codec power-up sequencer: waits, then writes a register table over I2C with NACK retry and re-init.
module codec_i2c_init_seq
  import codec_i2c_init_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned I2C_HZ       = 100_000,
  parameter int unsigned PWRUP_CYCLES = 60000,
  parameter logic [6:0]  DEV_ADDR     = 7'h10,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  codec_i2c_init_seq_if.master ctl,
  output logic                 i2c_sclk,
  inout  wire                  i2c_sdat
);

  localparam int unsigned QDIV = calc_qdiv(CLK_HZ, I2C_HZ);
  localparam int DW = $clog2(PWRUP_CYCLES + 1);

  seq_state_e    state, state_n;
  logic [DW-1:0] dly, dly_n;
  logic [7:0]    idx, idx_n;
  logic [3:0]    retry, retry_n;
  logic          pend, pend_n;
  logic          wr_start, latch_en;
  logic [7:0]    ent_addr, ent_val;
  logic          wr_done, wr_nack, wr_scl, wr_oe, sda_in;

  always_comb begin
    state_n  = state;
    dly_n    = dly;
    idx_n    = idx;
    retry_n  = retry;
    pend_n   = pend;
    wr_start = 1'b0;
    latch_en = 1'b0;
    unique case (state)
      ST_PWRUP: begin
        if (ctl.Reinit) begin
          dly_n = '0;
        end else if (dly == DW'(PWRUP_CYCLES - 1)) begin
          state_n = ST_LOAD;
          dly_n   = '0;
        end else begin
          dly_n = dly + DW'(1);
        end
      end
      ST_LOAD: begin
        latch_en = 1'b1;
        retry_n  = 4'd0;
        wr_start = 1'b1;
        state_n  = ST_XFER;
        if (ctl.Reinit) pend_n = 1'b1;
      end
      ST_XFER: begin
        if (ctl.Reinit) pend_n = 1'b1;
        if (wr_done) state_n = ST_CHECK;
      end
      ST_CHECK: begin
        // a re-init request seen during the transfer wins over the ACK outcome
        if (pend || ctl.Reinit) begin
          state_n = ST_PWRUP;
          dly_n   = '0;
          idx_n   = 8'd0;
          pend_n  = 1'b0;
        end else if (!wr_nack) begin
          if (idx == 8'(NUM_REGS - 1)) begin
            state_n = ST_DONE;
          end else begin
            idx_n   = idx + 8'd1;
            state_n = ST_LOAD;
          end
        end else if (retry < 4'(MAX_RETRY)) begin
          retry_n  = retry + 4'd1;
          wr_start = 1'b1;
          state_n  = ST_XFER;
        end else begin
          state_n = ST_ERR;
        end
      end
      ST_DONE, ST_ERR: begin
        if (ctl.Reinit) begin
          state_n = ST_PWRUP;
          dly_n   = '0;
          idx_n   = 8'd0;
        end
      end
      default: state_n = ST_PWRUP;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_PWRUP;
      dly   <= '0;
      idx   <= 8'd0;
      retry <= 4'd0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      dly   <= dly_n;
      idx   <= idx_n;
      retry <= retry_n;
      pend  <= pend_n;
    end
  end

  always_ff @(posedge Clk) begin
    if (latch_en) {ent_addr, ent_val} <= ctl.Tbl_Data;
  end

  codec_i2c_init_seq_byte_writer #(
    .QDIV(QDIV)
  ) u_writer (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .start    (wr_start),
    .dev_addr (DEV_ADDR),
    .reg_addr (ent_addr),
    .reg_value(ent_val),
    .sda_in   (sda_in),
    .done     (wr_done),
    .nack     (wr_nack),
    .scl      (wr_scl),
    .sda_oe   (wr_oe)
  );

  assign ctl.Tbl_Idx   = idx;
  assign ctl.Init_Done = (state == ST_DONE);
  assign ctl.Init_Err  = (state == ST_ERR);
  assign ctl.Busy      = !((state == ST_DONE) || (state == ST_ERR));
  assign i2c_sclk      = wr_scl;
  assign i2c_sdat      = wr_oe ? 1'b0 : 1'bz;
  assign sda_in        = i2c_sdat;

endmodule

// File: tb/tb_codec_i2c_init_seq.sv
// Directed bench for codec_i2c_init_seq with a behavioural I2C slave that logs and (N)ACKs writes.
module tb_codec_i2c_init_seq;

  localparam logic [23:0] E0 = 24'h200080;
  localparam logic [23:0] E1 = 24'h200104;
  localparam logic [23:0] E2 = 24'h200250;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  wire  scl_w;
  wire  sda_bus;
  logic slv_low = 1'b0;

  codec_i2c_init_seq_if ctl_if ();

  pullup (sda_bus);
  assign sda_bus = (slv_low && Rst_n) ? 1'b0 : 1'bz;

  always #10 Clk = ~Clk;

  codec_i2c_init_seq #(
    .CLK_HZ      (50_000_000),
    .I2C_HZ      (1_250_000),
    .PWRUP_CYCLES(100),
    .DEV_ADDR    (7'h10),
    .NUM_REGS    (3),
    .MAX_RETRY   (3)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .ctl     (ctl_if.master),
    .i2c_sclk(scl_w),
    .i2c_sdat(sda_bus)
  );

  always_comb begin
    case (ctl_if.Tbl_Idx)
      8'd0:    ctl_if.Tbl_Data = 16'h0080;
      8'd1:    ctl_if.Tbl_Data = 16'h0104;
      8'd2:    ctl_if.Tbl_Data = 16'h0250;
      default: ctl_if.Tbl_Data = 16'h0000;
    endcase
  end

  // Slave model: samples the bus on the falling Clk edge
  logic [23:0] tx_log[$];
  logic [7:0]  rx_b[3];
  logic [7:0]  sh = 8'h00;
  int          bit_cnt = 0;
  int          byte_cnt = 0;
  logic [7:0]  nack_reg = 8'hFF;
  int          nack_left = 0;
  logic        scl_d = 1'b1, sda_d = 1'b1, c_s, s_s, want_ack;

  always @(negedge Clk) begin
    c_s = scl_w;
    s_s = sda_bus;
    if (!Rst_n) begin
      bit_cnt = 0; byte_cnt = 0; slv_low = 1'b0;
    end else if (c_s && scl_d && sda_d && !s_s) begin
      bit_cnt = 0; byte_cnt = 0; slv_low = 1'b0;
    end else if (c_s && scl_d && !sda_d && s_s) begin
      if (byte_cnt == 3) tx_log.push_back({rx_b[0], rx_b[1], rx_b[2]});
      bit_cnt = 0; byte_cnt = 0;
    end else if (c_s && !scl_d) begin
      if (bit_cnt < 8) sh = {sh[6:0], s_s};
      bit_cnt++;
    end else if (!c_s && scl_d) begin
      if (bit_cnt == 8) begin
        if (byte_cnt < 3) rx_b[byte_cnt] = sh;
        want_ack = !(byte_cnt == 2 && rx_b[1] == nack_reg && nack_left != 0);
        if (!want_ack && nack_left > 0) nack_left--;
        slv_low = want_ack;
        byte_cnt++;
      end else if (bit_cnt == 9) begin
        slv_low = 1'b0;
        bit_cnt = 0;
      end
    end
    scl_d = c_s;
    sda_d = s_s;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input int n, input logic [23:0] w0, input logic [23:0] w1,
                           input logic [23:0] w2, input logic [23:0] w3, input logic [23:0] w4,
                           input logic [23:0] w5);
    logic [23:0] e[6];
    logic [31:0] obs;
    e[0] = w0; e[1] = w1; e[2] = w2; e[3] = w3; e[4] = w4; e[5] = w5;
    check_val({tag, "_count"}, tx_log.size(), n);
    for (int i = 0; i < n; i++) begin
      obs = (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF_FFFF;
      check_val($sformatf("%s_tx%0d", tag, i), obs, 32'(e[i]));
    end
  endtask

  task automatic measure_fall(output int n);
    n = 200;
    for (int i = 1; i <= 200; i++) begin
      @(posedge Clk); #1;
      if (sda_bus === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_end(input string tag);
    int k;
    k = 0;
    while (k < 20000 && !(ctl_if.Init_Done || ctl_if.Init_Err)) begin
      @(posedge Clk); #1;
      k++;
    end
    check_val(tag, 32'(k < 20000), 32'd1);
  endtask

  task automatic reinit_pulse();
    @(negedge Clk);
    ctl_if.Reinit = 1'b1;
    @(posedge Clk); #1;
    ctl_if.Reinit = 1'b0;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    ctl_if.Reinit = 1'b0;
    Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_val("rst_idx",  32'(ctl_if.Tbl_Idx),   32'd0);
    check_val("rst_done", 32'(ctl_if.Init_Done), 32'd0);
    check_val("rst_err",  32'(ctl_if.Init_Err),  32'd0);
    check_val("rst_busy", 32'(ctl_if.Busy),      32'd1);
    check_val("rst_scl",  32'(scl_w),            32'd1);
    check_val("rst_sda",  32'(sda_bus),          32'd1);

    // Plain power-up with an all-ACK slave
    @(negedge Clk);
    Rst_n = 1'b1;
    measure_fall(n);
    check_val("first_sda_fall", n, 111);
    wait_end("t1_end");
    check_log("t1", 3, E0, E1, E2, 0, 0, 0);
    check_val("t1_done", 32'(ctl_if.Init_Done), 32'd1);
    check_val("t1_busy", 32'(ctl_if.Busy),      32'd0);
    check_val("t1_err",  32'(ctl_if.Init_Err),  32'd0);

    // Re-init from DONE
    tx_log.delete();
    reinit_pulse();
    check_val("t2_done_drop", 32'(ctl_if.Init_Done), 32'd0);
    check_val("t2_busy",      32'(ctl_if.Busy),      32'd1);
    check_val("t2_idx",       32'(ctl_if.Tbl_Idx),   32'd0);
    measure_fall(n);
    check_val("t2_sda_fall", n, 111);
    wait_end("t2_end");
    check_log("t2", 3, E0, E1, E2, 0, 0, 0);
    check_val("t2_done", 32'(ctl_if.Init_Done), 32'd1);

    // Entry 1 NACKed twice, then accepted
    nack_reg = 8'h01; nack_left = 2;
    tx_log.delete();
    reinit_pulse();
    wait_end("t3_end");
    check_log("t3", 5, E0, E1, E1, E1, E2, 0);
    check_val("t3_done", 32'(ctl_if.Init_Done), 32'd1);
    check_val("t3_err",  32'(ctl_if.Init_Err),  32'd0);

    // Entry 2 always NACKed: retries exhausted
    nack_reg = 8'h02; nack_left = -1;
    tx_log.delete();
    reinit_pulse();
    wait_end("t4_end");
    check_log("t4", 6, E0, E1, E2, E2, E2, E2);
    check_val("t4_err",  32'(ctl_if.Init_Err),  32'd1);
    check_val("t4_done", 32'(ctl_if.Init_Done), 32'd0);
    check_val("t4_idx",  32'(ctl_if.Tbl_Idx),   32'd2);
    check_val("t4_busy", 32'(ctl_if.Busy),      32'd0);
    repeat (50) @(posedge Clk);
    #1;
    check_val("t4_scl", 32'(scl_w),   32'd1);
    check_val("t4_sda", 32'(sda_bus), 32'd1);

    // Re-init from ERR, then re-init again during the second byte of entry 1
    nack_left = 0;
    tx_log.delete();
    reinit_pulse();
    check_val("t5_err_clr", 32'(ctl_if.Init_Err), 32'd0);
    check_val("t5_idx_clr", 32'(ctl_if.Tbl_Idx),  32'd0);
    k = 0;
    while (k < 5000 && !(tx_log.size() == 1 && byte_cnt == 1)) begin
      @(posedge Clk); #1;
      k++;
    end
    check_val("t5_reach_e1b1", 32'(k < 5000), 32'd1);
    reinit_pulse();
    k = 0;
    while (k < 3000 && tx_log.size() < 2) begin
      @(posedge Clk); #1;
      k++;
    end
    check_val("t5_stop_seen", 32'(k < 3000), 32'd1);
    repeat (60) @(posedge Clk);
    #1;
    check_val("t5_idx_restart", 32'(ctl_if.Tbl_Idx), 32'd0);
    check_val("t5_busy",        32'(ctl_if.Busy),    32'd1);
    check_val("t5_sda_idle",    32'(sda_bus),        32'd1);
    wait_end("t5_end");
    check_log("t5", 5, E0, E1, E0, E1, E2, 0);
    check_val("t5_done", 32'(ctl_if.Init_Done), 32'd1);

    // Asynchronous reset in the middle of a transaction
    reinit_pulse();
    repeat (411) @(posedge Clk);
    #3;
    Rst_n = 1'b0;
    #1;
    check_val("t6_scl", 32'(scl_w),            32'd1);
    check_val("t6_sda", 32'(sda_bus),          32'd1);
    check_val("t6_idx", 32'(ctl_if.Tbl_Idx),   32'd0);
    check_val("t6_busy", 32'(ctl_if.Busy),     32'd1);
    repeat (5) @(posedge Clk);
    tx_log.delete();
    @(negedge Clk);
    Rst_n = 1'b1;
    measure_fall(n);
    check_val("t6_sda_fall", n, 111);
    wait_end("t6_end");
    check_log("t6", 3, E0, E1, E2, 0, 0, 0);
    check_val("t6_done", 32'(ctl_if.Init_Done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
